// File: rtl/r2mdc_commutator.sv
// Delay-commutator between two radix-2 butterflies of an R2MDC FFT pipeline.
// Reorders the (Y0, Y1) streams into (A, B) operand pairs spaced DELAY samples apart.
module r2mdc_commutator #(
   parameter int DATA_W = 16,
   parameter int DELAY  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] x0_re,
   input  logic [DATA_W-1:0] x0_im,
   input  logic [DATA_W-1:0] x1_re,
   input  logic [DATA_W-1:0] x1_im,
   output logic              out_valid,
   output logic [DATA_W-1:0] y0_re,
   output logic [DATA_W-1:0] y0_im,
   output logic [DATA_W-1:0] y1_re,
   output logic [DATA_W-1:0] y1_im,
   output logic              frame_err
);

   localparam int CNT_W = $clog2(2 * DELAY);
   localparam int SEL_B = $clog2(DELAY);
   localparam int CW    = 2 * DATA_W;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CW-1:0]    l_q [DELAY];
   logic [CW-1:0]    l_d [DELAY];
   logic [CW-1:0]    u_q [DELAY];
   logic [CW-1:0]    u_d [DELAY];
   logic [DELAY:0]   vld_q, vld_d;
   logic [CW-1:0]    y0_q, y0_d, y1_q, y1_d;
   logic             frame_err_q, frame_err_d;

   logic             sel;
   logic [CW-1:0]    x0_c, x1_c, l_c, p_c, q_c;

   always_comb begin
      x0_c = {x0_re, x0_im};
      x1_c = {x1_re, x1_im};
      l_c  = l_q[DELAY-1];
      // Second half of each frame crosses: delayed x1 goes up, live x0 goes down.
      sel  = cnt_q[SEL_B];
      p_c  = sel ? l_c  : x0_c;
      q_c  = sel ? x0_c : l_c;

      cnt_d       = in_valid ? cnt_q + CNT_W'(1) : cnt_q;
      frame_err_d = frame_err_q | (~in_valid & (cnt_q != '0));
      vld_d       = {vld_q[DELAY-1:0], in_valid};

      l_d[0] = x1_c;
      u_d[0] = p_c;
      for (int i = 1; i < DELAY; i++) begin
         l_d[i] = l_q[i-1];
         u_d[i] = u_q[i-1];
      end

      y0_d = u_q[DELAY-1];
      y1_d = q_c;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= '0;
         vld_q       <= '0;
         y0_q        <= '0;
         y1_q        <= '0;
         frame_err_q <= 1'b0;
         for (int i = 0; i < DELAY; i++) begin
            l_q[i] <= '0;
            u_q[i] <= '0;
         end
      end else begin
         cnt_q       <= cnt_d;
         vld_q       <= vld_d;
         y0_q        <= y0_d;
         y1_q        <= y1_d;
         frame_err_q <= frame_err_d;
         for (int i = 0; i < DELAY; i++) begin
            l_q[i] <= l_d[i];
            u_q[i] <= u_d[i];
         end
      end
   end

   assign out_valid = vld_q[DELAY];
   assign frame_err = frame_err_q;
   assign y0_re     = y0_q[CW-1:DATA_W];
   assign y0_im     = y0_q[DATA_W-1:0];
   assign y1_re     = y1_q[CW-1:DATA_W];
   assign y1_im     = y1_q[DATA_W-1:0];

endmodule

// File: tb/tb_r2mdc_commutator.sv
// Bench for r2mdc_commutator: three instances (DELAY 1, 2, 4) sharing data and reset,
// each with its own in_valid; a tagged expected queue holds (instance, cycle, pair).
module tb_r2mdc_commutator;

   localparam int W = 98;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  iv;
   logic [15:0] x0r, x0i, x1r, x1i;
   logic        ov [3];
   logic        fe [3];
   logic [15:0] y0r [3];
   logic [15:0] y0i [3];
   logic [15:0] y1r [3];
   logic [15:0] y1i [3];

   int          cyc = 0;
   int          n_tests = 0;
   int          n_fail = 0;
   bit          mon_en = 1'b0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] mon_e;
   logic [15:0] a_re [64];
   logic [15:0] a_im [64];
   logic [15:0] b_re [64];
   logic [15:0] b_im [64];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   r2mdc_commutator #(.DATA_W(16), .DELAY(1)) u_d1 (
      .clk(clk), .rst(rst), .in_valid(iv[0]),
      .x0_re(x0r), .x0_im(x0i), .x1_re(x1r), .x1_im(x1i),
      .out_valid(ov[0]), .y0_re(y0r[0]), .y0_im(y0i[0]),
      .y1_re(y1r[0]), .y1_im(y1i[0]), .frame_err(fe[0]));

   r2mdc_commutator #(.DATA_W(16), .DELAY(2)) u_d2 (
      .clk(clk), .rst(rst), .in_valid(iv[1]),
      .x0_re(x0r), .x0_im(x0i), .x1_re(x1r), .x1_im(x1i),
      .out_valid(ov[1]), .y0_re(y0r[1]), .y0_im(y0i[1]),
      .y1_re(y1r[1]), .y1_im(y1i[1]), .frame_err(fe[1]));

   r2mdc_commutator #(.DATA_W(16), .DELAY(4)) u_d4 (
      .clk(clk), .rst(rst), .in_valid(iv[2]),
      .x0_re(x0r), .x0_im(x0i), .x1_re(x1r), .x1_im(x1i),
      .out_valid(ov[2]), .y0_re(y0r[2]), .y0_im(y0i[2]),
      .y1_re(y1r[2]), .y1_im(y1i[2]), .frame_err(fe[2]));

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_data();
      x0r = 16'($urandom_range(0, 16'hFFFF));
      x0i = 16'($urandom_range(0, 16'hFFFF));
      x1r = 16'($urandom_range(0, 16'hFFFF));
      x1i = 16'($urandom_range(0, 16'hFFFF));
   endtask

   task automatic beat(input int idx, input bit v, input logic [15:0] ar, ai, br, bi);
      iv      = '0;
      iv[idx] = v;
      x0r = ar; x0i = ai; x1r = br; x1i = bi;
      step();
   endtask

   task automatic idle(input int n);
      iv = '0;
      for (int k = 0; k < n; k++) begin
         rand_data();
         step();
      end
   endtask

   // Reference reorder: first D cycles emit (A[j], A[j+D]), next D emit (B[j], B[j+D]).
   task automatic run_stream(input int idx, input int d, input int nbeats);
      int c0 = cyc;
      for (int f = 0; f < nbeats / (2 * d); f++) begin
         int base = 2 * d * f;
         for (int j = 0; j < d; j++)
            exp_q.push_back({2'(idx), 32'(c0 + base + d + 1 + j),
                             a_re[base+j], a_im[base+j], a_re[base+j+d], a_im[base+j+d]});
         for (int j = 0; j < d; j++)
            exp_q.push_back({2'(idx), 32'(c0 + base + 2 * d + 1 + j),
                             b_re[base+j], b_im[base+j], b_re[base+j+d], b_im[base+j+d]});
      end
      for (int k = 0; k < nbeats; k++)
         beat(idx, 1'b1, a_re[k], a_im[k], b_re[k], b_im[k]);
      iv = '0;
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         for (int i = 0; i < 3; i++) begin
            if (ov[i]) begin
               if (exp_q.size() == 0 || exp_q[0][97:96] != 2'(i)) begin
                  check_eq($sformatf("unexpected_valid_d%0d", i), {63'b0, ov[i]}, 64'd0);
               end else begin
                  mon_e = exp_q.pop_front();
                  check_eq($sformatf("out_cycle_d%0d", i), 64'(cyc), {32'b0, mon_e[95:64]});
                  check_eq($sformatf("out_pair_d%0d", i), {y0r[i], y0i[i], y1r[i], y1i[i]},
                           mon_e[63:0]);
               end
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      iv  = '0;
      rand_data();

      // Reset with random inputs
      repeat (2) begin
         iv = 3'($urandom_range(0, 7));
         rand_data();
         @(posedge clk);
      end
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check_eq($sformatf("rst_valid_d%0d", i), {63'b0, ov[i]}, 64'd0);
         check_eq($sformatf("rst_ferr_d%0d", i), {63'b0, fe[i]}, 64'd0);
         check_eq($sformatf("rst_data_d%0d", i), {y0r[i], y0i[i], y1r[i], y1i[i]}, 64'd0);
      end
      iv = '0;
      step();
      rst    = 1'b0;
      mon_en = 1'b1;
      idle(2);

      // Single frame, DELAY=2
      for (int k = 0; k < 4; k++) begin
         a_re[k] = 16'(16'h0100 * (k + 1));
         a_im[k] = a_re[k] + 16'd1;
         b_re[k] = 16'(16'h1100 + 16'h0100 * k);
         b_im[k] = b_re[k] + 16'd1;
      end
      run_stream(1, 2, 4);
      idle(8);
      check_eq("drain_single_d2", 64'(exp_q.size()), 64'd0);
      check_eq("ferr_single_d2", {63'b0, fe[1]}, 64'd0);

      // Three back-to-back frames, DELAY=4
      for (int k = 0; k < 24; k++) begin
         a_re[k] = 16'(16'h0010 + k);
         a_im[k] = 16'(16'h2000 + k);
         b_re[k] = 16'(16'h4000 + k);
         b_im[k] = 16'(16'hC000 + k);
      end
      run_stream(2, 4, 24);
      idle(12);
      check_eq("drain_b2b_d4", 64'(exp_q.size()), 64'd0);
      check_eq("ferr_b2b_d4", {63'b0, fe[2]}, 64'd0);

      // Sign / extreme values, DELAY=1
      a_re[0] = 16'h8000; a_im[0] = 16'h7FFF; b_re[0] = 16'hFFFF; b_im[0] = 16'h0001;
      a_re[1] = 16'h7FFF; a_im[1] = 16'h8000; b_re[1] = 16'h0001; b_im[1] = 16'hFFFF;
      run_stream(0, 1, 2);
      idle(4);
      check_eq("drain_ext_d1", 64'(exp_q.size()), 64'd0);
      check_eq("ferr_ext_d1", {63'b0, fe[0]}, 64'd0);

      // Mid-frame gap, DELAY=2; output pairing across the gap is undefined
      mon_en = 1'b0;
      beat(1, 1'b1, 16'h0A00, 16'h0A01, 16'h0B00, 16'h0B01);
      beat(1, 1'b1, 16'h0A10, 16'h0A11, 16'h0B10, 16'h0B11);
      iv = '0;
      @(negedge clk);
      check_eq("ferr_pre_gap", {63'b0, fe[1]}, 64'd0);
      step();
      @(negedge clk);
      check_eq("ferr_gap_set", {63'b0, fe[1]}, 64'd1);
      step();
      beat(1, 1'b1, 16'h0A20, 16'h0A21, 16'h0B20, 16'h0B21);
      beat(1, 1'b1, 16'h0A30, 16'h0A31, 16'h0B30, 16'h0B31);
      idle(6);
      check_eq("ferr_sticky", {63'b0, fe[1]}, 64'd1);
      rst = 1'b1;
      step();
      @(negedge clk);
      check_eq("ferr_cleared", {63'b0, fe[1]}, 64'd0);
      check_eq("valid_after_rst", {63'b0, ov[1]}, 64'd0);
      step();
      rst    = 1'b0;
      mon_en = 1'b1;
      idle(2);

      // Reset during beat 3 of a DELAY=4 frame, then a clean frame
      for (int k = 0; k < 3; k++)
         beat(2, 1'b1, 16'(16'h5000 + k), 16'(16'h6000 + k), 16'(16'h7000 + k), 16'(16'h9000 + k));
      rst = 1'b1;
      beat(2, 1'b1, 16'h5003, 16'h6003, 16'h7003, 16'h9003);
      iv = '0;
      @(negedge clk);
      check_eq("midrst_valid", {63'b0, ov[2]}, 64'd0);
      check_eq("midrst_data", {y0r[2], y0i[2], y1r[2], y1i[2]}, 64'd0);
      step();
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         a_re[k] = 16'($urandom_range(0, 16'hFFFF));
         a_im[k] = 16'($urandom_range(0, 16'hFFFF));
         b_re[k] = 16'($urandom_range(0, 16'hFFFF));
         b_im[k] = 16'($urandom_range(0, 16'hFFFF));
      end
      run_stream(2, 4, 8);
      idle(10);
      check_eq("drain_midrst_d4", 64'(exp_q.size()), 64'd0);
      check_eq("ferr_midrst_d4", {63'b0, fe[2]}, 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/r2mdc_commutator.md
# r2mdc_commutator

Delay-commutator stage of the R2MDC pipeline FFT. It sits between two `bf_radix2` butterflies. It takes the upper (Y0) and lower (Y1) complex output streams of one butterfly and reorders them with two DELAY-deep delay lines and a 2x2 switch. The result is the (A, B) operand pairs the next butterfly needs, spaced DELAY samples apart. Data is 16-bit two's-complement fixed point (1 sign, 7 integer, 8 fractional bits) and passes through unmodified.

## Interface
- `DATA_W`, 16: width of each real/imag component.
- `DELAY`, 4: commutator distance D, equal to N/2^(s+1) for the downstream stage. Must be a power of two, ≥1.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  marks a valid input pair this cycle.
- `x0_re`, `x0_im`  in  DATA_W each  upper input (upstream butterfly Y0).
- `x1_re`, `x1_im`  in  DATA_W each  lower input (upstream butterfly Y1).
- `out_valid`  out  1  marks a valid output pair.
- `y0_re`, `y0_im`  out  DATA_W each  upper output (downstream butterfly A).
- `y1_re`, `y1_im`  out  DATA_W each  lower output (downstream butterfly B).
- `frame_err`  out  1  sticky flag: a frame was broken by a mid-frame gap.

## Operation
- A frame is 2·DELAY consecutive `in_valid` beats. Frames may follow back-to-back, or be separated by idle cycles only at frame boundaries.
- Beat counter `cnt`:
  - log2(2·DELAY) bits, reset to 0.
  - Increments on each `in_valid` beat and wraps from 2·DELAY−1 to 0.
  - Switch select `sel` = `cnt[log2(DELAY)]`: 0 = straight, 1 = cross.
- Lower delay line L: x1 passes through DELAY register stages, giving `l`.
- Switch, combinational:
  - Straight: `p = x0`, `q = l`.
  - Cross: `p = l`, `q = x0`.
- Upper delay line U: `p` passes through DELAY register stages, giving `pu`.
- Output registers (one stage): `y0 <= pu`, `y1 <= q`.
- Both delay lines and the valid pipeline shift every cycle, regardless of `in_valid`. Invalid cycles shift in whatever data is present; those slots are never marked valid.
- Valid pipeline: DELAY+1 stages, so `out_valid(t) = in_valid(t−DELAY−1)`.
- `frame_err` is set when `in_valid=0` while `cnt≠0`. It stays set until `rst`.
  - After a gap, `cnt` holds its value and resumes counting when `in_valid` returns.
  - Output pairing across the gap is undefined.
- No arithmetic, rounding or saturation. Components are copied bit-exact.
- Reset values, applied on the first rising edge with `rst=1`:
  - `cnt`, all delay-line registers, `y0_*`, `y1_*` = 0.
  - `out_valid` = 0, `frame_err` = 0.
- Reset mid-frame discards all in-flight samples. `out_valid` is 0 from the next cycle. The first `in_valid` after reset starts a new frame at `cnt=0`.

## Timing
- Latency is DELAY+1 cycles from an input beat to the output beat that starts emitting its frame.
- Output order for an input frame (x0 = A0..A(2D−1), x1 = B0..B(2D−1)):
  - Cycles D+1 .. 2D: pairs (A0, AD) .. (A(D−1), A(2D−1)).
  - Cycles 2D+1 .. 3D: pairs (B0, BD) .. (B(D−1), B(2D−1)).
- Throughput is one pair per cycle. Back-to-back frames produce a continuous `out_valid`.
- A single frame followed by idle still flushes completely. The datapath shifts every cycle, so no trailing input is required.
- DELAY=1 degenerates to a single-stage L, a single-stage U, and a switch that alternates every beat.

## Test plan
- **Reset values.** Hold `rst` 2 cycles with random inputs → all outputs 0, `out_valid=0`, `frame_err=0`.
- **Single frame, DELAY=2.**
  - Stimulus: x0_re = 0x0100, 0x0200, 0x0300, 0x0400 and x1_re = 0x1100, 0x1200, 0x1300, 0x1400 at cycles 0–3; imag = re+1.
  - Required: `out_valid` high at cycles 3–6 only.
  - (y0_re, y1_re) = (0x0100, 0x0300), (0x0200, 0x0400), (0x1100, 0x1300), (0x1200, 0x1400).
  - Imag parts follow identically.
- **Back-to-back frames, DELAY=4.** 3 contiguous frames of incrementing data → `out_valid` continuous for 24 cycles starting at cycle 5; every pair matches the reference reorder; `frame_err=0`.
- **Mid-frame gap.** DELAY=2; deassert `in_valid` after beat 1 → `frame_err` = 1 the following cycle and stays 1 after the gap closes; clears only on `rst`.
- **Reset mid-frame.** Assert `rst` during beat 3 of a DELAY=4 frame → `out_valid=0` the next cycle and outputs 0. A new full frame then reorders correctly, with first output 5 cycles after its first beat.
- **Sign/extreme values.** DELAY=1 frame with x0 = 0x8000, 0x7FFF and x1 = 0xFFFF, 0x0001 → at cycles 2–3: (0x8000, 0x7FFF), then (0xFFFF, 0x0001), bit-exact.
